// File: rtl/my_verilog_pkg.sv
// Local-bus register map for the PL register block.
// Address constants and default read values.
package my_verilog_pkg;

    localparam logic [15:0] ADDR_ID      = 16'h0000;
    localparam logic [15:0] ADDR_LED     = 16'h0001;
    localparam logic [15:0] ADDR_SCRATCH = 16'h0002;
    localparam logic [15:0] ADDR_CNT_LO  = 16'h0003;
    localparam logic [15:0] ADDR_CNT_HI  = 16'h0004;
    localparam logic [15:0] ADDR_WRCOUNT = 16'h0005;
    localparam logic [15:0] ADDR_A7COUNT = 16'h0006;

    localparam logic [15:0] ID_DEFAULT       = 16'hBEEF;
    localparam logic [15:0] UNMAPPED_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/my_verilog.sv
// PL register block: decodes local-bus strobes into ID, LED, scratch,
// cycle counter with coherent HI shadow, and write/A7 activity counters.
module my_verilog
    import my_verilog_pkg::*;
#(
    parameter logic [15:0] ID_VALUE       = ID_DEFAULT,
    parameter logic [15:0] UNMAPPED_VALUE = UNMAPPED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baddr,
    input  logic [15:0] bwrdata,
    input  logic        bwr,
    input  logic        bstrobe,
    input  logic        do_a7_write,
    output logic [15:0] brddata,
    output logic [7:0]  led
);

    logic [31:0] cnt;
    logic [15:0] cnt_hi;
    logic [15:0] scratch;
    logic [15:0] wrcount;
    logic [15:0] a7count;
    logic        local_wr;
    logic        local_rd;
    logic        a7_txn;

    // A7 transactions are never decoded locally, whatever bwr says
    assign local_wr = bstrobe & bwr & ~do_a7_write;
    assign local_rd = bstrobe & ~bwr & ~do_a7_write;
    assign a7_txn   = bstrobe & do_a7_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            cnt_hi  <= '0;
            led     <= '0;
            scratch <= '0;
            wrcount <= '0;
            a7count <= '0;
        end else begin
            cnt <= cnt + 32'd1;
            // Shadow the pre-edge upper half so LO/HI read as one snapshot
            if (local_rd && baddr == ADDR_CNT_LO) begin
                cnt_hi <= cnt[31:16];
            end
            if (local_wr) begin
                if (baddr == ADDR_WRCOUNT) begin
                    wrcount <= '0;
                end else begin
                    wrcount <= wrcount + 16'd1;
                end
                if (baddr == ADDR_LED) begin
                    led <= bwrdata[7:0];
                end
                if (baddr == ADDR_SCRATCH) begin
                    scratch <= bwrdata;
                end
                if (baddr == ADDR_A7COUNT) begin
                    a7count <= '0;
                end
            end
            if (a7_txn) begin
                a7count <= a7count + 16'd1;
            end
        end
    end

    always_comb begin
        brddata = UNMAPPED_VALUE;
        case (baddr)
            ADDR_ID:      brddata = ID_VALUE;
            ADDR_LED:     brddata = {8'h00, led};
            ADDR_SCRATCH: brddata = scratch;
            ADDR_CNT_LO:  brddata = cnt[15:0];
            ADDR_CNT_HI:  brddata = cnt_hi;
            ADDR_WRCOUNT: brddata = wrcount;
            ADDR_A7COUNT: brddata = a7count;
            default:      brddata = UNMAPPED_VALUE;
        endcase
    end

endmodule

// File: tb/tb_my_verilog.sv
// Scoreboard bench for my_verilog: reads push expected values,
// a negedge monitor pops and compares brddata and led.
module tb_my_verilog;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baddr;
    logic [15:0] bwrdata;
    logic        bwr;
    logic        bstrobe;
    logic        do_a7_write;
    logic [15:0] brddata;
    logic [7:0]  led;

    typedef struct {
        string       name;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  led;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] exp_led;

    my_verilog dut (
        .clk(clk),
        .reset(reset),
        .baddr(baddr),
        .bwrdata(bwrdata),
        .bwr(bwr),
        .bstrobe(bstrobe),
        .do_a7_write(do_a7_write),
        .brddata(brddata),
        .led(led)
    );

    always #5 clk = ~clk;

    // Monitor: every local read cycle presents a result to check
    always @(negedge clk) begin
        if (!reset && bstrobe && !bwr && !do_a7_write) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_read addr=%h got=%h", baddr,
                         brddata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (brddata < e.lo || brddata > e.hi) begin
                    n_fail++;
                    $display("FAIL %s: brddata got=%h want=[%h,%h]",
                             e.name, brddata, e.lo, e.hi);
                end
                n_cmp++;
                if (led !== e.led) begin
                    n_fail++;
                    $display("FAIL %s_led: led got=%h want=%h",
                             e.name, led, e.led);
                end
            end
        end
    end

    task automatic cyc(input logic s, input logic w, input logic a7,
                       input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        bstrobe     = s;
        bwr         = w;
        do_a7_write = a7;
        baddr       = a;
        bwrdata     = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rdr(input string n, input logic [15:0] a,
                       input logic [15:0] lo, input logic [15:0] hi);
        exp_t e;
        e.name = n;
        e.lo   = lo;
        e.hi   = hi;
        e.led  = exp_led;
        exp_q.push_back(e);
        cyc(1'b1, 1'b0, 1'b0, a, 16'h0000);
    endtask

    task automatic rd(input string n, input logic [15:0] a,
                      input logic [15:0] v);
        rdr(n, a, v, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bstrobe = 1'b0;
        bwr = 1'b0;
        do_a7_write = 1'b0;
        baddr = '0;
        bwrdata = '0;
        exp_led = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        rd("rst_id", 16'h0000, 16'hBEEF);
        rd("rst_led", 16'h0001, 16'h0000);
        rd("rst_scratch", 16'h0002, 16'h0000);
        rdr("rst_cntlo", 16'h0003, 16'd1, 16'd10);
        rd("rst_cnthi", 16'h0004, 16'h0000);
        rd("rst_wrcount", 16'h0005, 16'h0000);
        rd("rst_a7count", 16'h0006, 16'h0000);
        rd("rst_unmapped", 16'h0007, 16'hDEAD);

        wr(16'h0001, 16'h12A5);
        exp_led = 8'hA5;
        rd("led_rb", 16'h0001, 16'h00A5);
        wr(16'h0002, 16'h5A5A);
        rd("scratch_rb", 16'h0002, 16'h5A5A);
        wr(16'h0007, 16'h1234);
        rd("unmapped_wr", 16'h0007, 16'hDEAD);
        rd("wrcount_3", 16'h0005, 16'd3);
        wr(16'h0005, 16'hFFFF);
        rd("wrcount_clr", 16'h0005, 16'd0);
        wr(16'h0000, 16'h1111);
        rd("id_ro", 16'h0000, 16'hBEEF);
        rd("wrcount_1", 16'h0005, 16'd1);

        cyc(1'b1, 1'b1, 1'b1, 16'h0001, 16'h00FF);
        rd("a7_led", 16'h0001, 16'h00A5);
        rd("a7count_1", 16'h0006, 16'd1);
        rd("a7_wrcount", 16'h0005, 16'd1);
        cyc(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0000);
        rd("a7count_3", 16'h0006, 16'd3);
        wr(16'h0006, 16'h0000);
        rd("a7count_clr", 16'h0006, 16'd0);
        rd("wrcount_2", 16'h0005, 16'd2);

        @(posedge clk);
        #1;
        reset = 1'b1;
        bstrobe = 1'b1;
        bwr = 1'b1;
        do_a7_write = 1'b0;
        baddr = 16'h0002;
        bwrdata = 16'hFFFF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bstrobe = 1'b0;
        exp_led = 8'h00;
        rd("mid_scratch", 16'h0002, 16'h0000);
        rd("mid_wrcount", 16'h0005, 16'h0000);
        rd("mid_a7count", 16'h0006, 16'h0000);
        rd("mid_led", 16'h0001, 16'h0000);

        idle();
        repeat (100) @(posedge clk);
        rdr("cnt_lo_100", 16'h0003, 16'd100, 16'd115);
        rd("cnt_hi_snap", 16'h0004, 16'h0000);
        rd("cnt_hi_hold", 16'h0004, 16'h0000);
        idle();

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expected reads left, want 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
